// File: rtl/bridge_axi_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI-lite bridge slave among N requesters.
// One complete write or read is granted at a time and its response is routed back to the grantee.
module bridge_axi_arbiter #(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [N-1:0]            s_awvalid,
    input  logic [N-1:0]            s_wvalid,
    input  logic [N-1:0]            s_arvalid,
    input  logic [N-1:0]            s_bready,
    input  logic [N-1:0]            s_rready,
    input  logic [N*ADDR_W-1:0]     s_awaddr,
    input  logic [N*ADDR_W-1:0]     s_araddr,
    input  logic [N*3-1:0]          s_awprot,
    input  logic [N*3-1:0]          s_arprot,
    input  logic [N*DATA_W-1:0]     s_wdata,
    input  logic [N*DATA_W/8-1:0]   s_wstrb,
    output logic [N-1:0]            s_awready,
    output logic [N-1:0]            s_wready,
    output logic [N-1:0]            s_arready,
    output logic [N-1:0]            s_bvalid,
    output logic [N-1:0]            s_rvalid,
    output logic [1:0]              s_bresp,
    output logic [1:0]              s_rresp,
    output logic [DATA_W-1:0]       s_rdata,
    output logic                    m_awvalid,
    output logic [ADDR_W-1:0]       m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    output logic                    m_arvalid,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_bready,
    output logic                    m_rready,
    input  logic                    m_awready,
    input  logic                    m_wready,
    input  logic                    m_arready,
    input  logic                    m_bvalid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_rvalid,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic [1:0]              m_rresp,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    typedef enum logic [2:0] {IDLE, FWD_W, FWD_R, WAIT_B, WAIT_R} state_t;

    state_t              state, state_nxt;
    logic [2:0]          last, last_nxt, grant, grant_nxt;
    logic                aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic [N-1:0]        write_pend, eligible, gnt_oh, elig_sh;
    logic                found, pick_write, aw_hs, w_hs;
    logic [2:0]          pick;
    int                  idx;

    logic                sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
    logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
    logic [2:0]          sel_awprot, sel_arprot;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wstrb;

    assign write_pend = s_awvalid & s_wvalid;
    assign eligible   = write_pend | s_arvalid;
    assign gnt_oh     = N'(1) << grant;
    assign busy       = (state != IDLE);
    assign grant_id   = grant;

    // Round-robin search starting just after the last completed requester.
    always_comb begin
        found   = 1'b0;
        pick    = 3'd0;
        idx     = 0;
        elig_sh = '0;
        for (int k = 1; k <= N; k++) begin
            idx     = (int'(last) + k) % N;
            elig_sh = eligible >> idx;
            if (!found && elig_sh[0]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
        pick_write = |(write_pend & (N'(1) << pick));
    end

    always_comb begin
        sel_awvalid = 1'b0;
        sel_wvalid  = 1'b0;
        sel_arvalid = 1'b0;
        sel_bready  = 1'b0;
        sel_rready  = 1'b0;
        sel_awaddr  = '0;
        sel_araddr  = '0;
        sel_awprot  = '0;
        sel_arprot  = '0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == 3'(i)) begin
                sel_awvalid = s_awvalid[i];
                sel_wvalid  = s_wvalid[i];
                sel_arvalid = s_arvalid[i];
                sel_bready  = s_bready[i];
                sel_rready  = s_rready[i];
                sel_awaddr  = s_awaddr[i*ADDR_W +: ADDR_W];
                sel_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
                sel_awprot  = s_awprot[i*3 +: 3];
                sel_arprot  = s_arprot[i*3 +: 3];
                sel_wdata   = s_wdata[i*DATA_W +: DATA_W];
                sel_wstrb   = s_wstrb[i*(DATA_W/8) +: DATA_W/8];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_nxt    = last;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        s_awready   = '0;
        s_wready    = '0;
        s_arready   = '0;
        s_bvalid    = '0;
        s_rvalid    = '0;
        s_bresp     = '0;
        s_rresp     = '0;
        s_rdata     = '0;
        m_awvalid   = 1'b0;
        m_awaddr    = '0;
        m_awprot    = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arprot    = '0;
        m_bready    = 1'b0;
        m_rready    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    if (pick_write) begin
                        state_nxt   = FWD_W;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                    end else begin
                        state_nxt = FWD_R;
                    end
                end
            end
            FWD_W: begin
                m_awvalid   = sel_awvalid & ~aw_done;
                m_awaddr    = sel_awaddr;
                m_awprot    = sel_awprot;
                m_wvalid    = sel_wvalid & ~w_done;
                m_wdata     = sel_wdata;
                m_wstrb     = sel_wstrb;
                // Ready is withheld once a channel completed so it cannot handshake twice.
                s_awready   = gnt_oh & {N{m_awready & ~aw_done}};
                s_wready    = gnt_oh & {N{m_wready & ~w_done}};
                aw_hs       = sel_awvalid & ~aw_done & m_awready;
                w_hs        = sel_wvalid & ~w_done & m_wready;
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) state_nxt = WAIT_B;
            end
            WAIT_B: begin
                m_bready = sel_bready;
                s_bvalid = gnt_oh & {N{m_bvalid}};
                s_bresp  = m_bresp;
                if (m_bvalid && sel_bready) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            FWD_R: begin
                m_arvalid = sel_arvalid;
                m_araddr  = sel_araddr;
                m_arprot  = sel_arprot;
                s_arready = gnt_oh & {N{m_arready}};
                if (sel_arvalid && m_arready) state_nxt = WAIT_R;
            end
            WAIT_R: begin
                m_rready = sel_rready;
                s_rvalid = gnt_oh & {N{m_rvalid}};
                s_rresp  = m_rresp;
                s_rdata  = m_rdata;
                if (m_rvalid && sel_rready) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            last    <= 3'(N-1);
            grant   <= 3'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            grant   <= grant_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_bridge_axi_arbiter.sv
// Self-checking bench for bridge_axi_arbiter with N=4: a bridge-side responder driven from tasks
// and a queue of expected grants/results compared as transactions complete.
module tb_bridge_axi_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              res;
    logic [N-1:0]      s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
    logic [N*AW-1:0]   s_awaddr, s_araddr;
    logic [N*3-1:0]    s_awprot, s_arprot;
    logic [N*DW-1:0]   s_wdata;
    logic [N*DW/8-1:0] s_wstrb;
    logic [N-1:0]      s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [1:0]        s_bresp, s_rresp;
    logic [DW-1:0]     s_rdata;
    logic              m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic [2:0]        m_awprot, m_arprot;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    logic [1:0]        m_bresp, m_rresp;
    logic [DW-1:0]     m_rdata;
    logic              busy;
    logic [2:0]        grant_id;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int          r_id;
    bit          r_wr, r_tmo;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [N-1:0] r_vec;

    always #5 clk = ~clk;

    bridge_axi_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .res(res),
        .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_arvalid(s_arvalid),
        .s_bready(s_bready), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_araddr(s_araddr), .s_awprot(s_awprot), .s_arprot(s_arprot),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready),
        .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
        .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_bready(m_bready), .m_rready(m_rready),
        .m_awready(m_awready), .m_wready(m_wready), .m_arready(m_arready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic clear_inputs();
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_bready  = '1; s_rready = '1;
        s_awaddr  = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0;
        s_wdata   = '0; s_wstrb  = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid  = 1'b0; m_bresp  = '0;
        m_rvalid  = 1'b0; m_rdata  = '0; m_rresp = '0;
    endtask

    task automatic do_reset();
        res = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        #1;
    endtask

    task automatic set_read(input int i, input logic [31:0] addr);
        s_arvalid[i[1:0]] = 1'b1;
        s_araddr[i*AW +: AW] = addr;
    endtask

    task automatic set_write(input int i, input logic [31:0] addr, input logic [31:0] data);
        s_awvalid[i[1:0]] = 1'b1;
        s_wvalid[i[1:0]]  = 1'b1;
        s_awaddr[i*AW +: AW] = addr;
        s_wdata[i*DW +: DW]  = data;
        s_wstrb[i*4 +: 4]    = 4'hF;
    endtask

    // Bridge-side responder: waits for a grant, accepts it, answers, returns what it observed.
    // Read data is derived from the address the bridge saw: 0xA0 + addr[11:8].
    task automatic run_txn(input bit keep, output int id, output bit is_wr, output logic [31:0] addr,
                           output logic [31:0] wdata, output logic [N-1:0] rsp_vec,
                           output logic [31:0] rdata, output bit tmo);
        int cyc;
        logic [1:0] g;
        tmo = 1'b0; cyc = 0; id = 0; is_wr = 1'b0; addr = '0; wdata = '0; rsp_vec = '0; rdata = '0;
        while (!busy && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!busy) begin
            tmo = 1'b1;
            return;
        end
        id = int'(grant_id);
        g  = grant_id[1:0];
        if (m_awvalid) begin
            is_wr = 1'b1; addr = m_awaddr; wdata = m_wdata;
            m_awready = 1'b1; m_wready = 1'b1;
            @(posedge clk); @(negedge clk);
            m_awready = 1'b0; m_wready = 1'b0;
            s_awvalid[g] = 1'b0; s_wvalid[g] = 1'b0;
            m_bvalid = 1'b1; m_bresp = 2'b00;
            #1 rsp_vec = s_bvalid;
            @(posedge clk); @(negedge clk);
            m_bvalid = 1'b0;
            #1;
        end else begin
            addr = m_araddr;
            m_arready = 1'b1;
            @(posedge clk); @(negedge clk);
            m_arready = 1'b0;
            if (!keep) s_arvalid[g] = 1'b0;
            m_rvalid = 1'b1;
            m_rdata  = 32'hA0 + {28'd0, addr[11:8]};
            #1;
            rsp_vec = s_rvalid;
            rdata   = s_rdata;
            @(posedge clk); @(negedge clk);
            m_rvalid = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        clear_inputs();
        s_awvalid = '1; s_wvalid = '1; s_arvalid = '1;
        @(negedge clk); @(negedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        tests_run++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin tests_failed++; $display("FAIL reset_m_valids: got %b expected 00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
        tests_run++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== '0) begin tests_failed++; $display("FAIL reset_s_outputs: got %h expected 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
        @(negedge clk);
        res = 1'b0;
        #1;
        tests_run++; if (m_awvalid !== 1'b0) begin tests_failed++; $display("FAIL idle_no_comb_path: got %b expected 0", m_awvalid); end
        @(posedge clk); @(negedge clk); #1;
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL first_grant_after_reset: got %0d expected 0", grant_id); end
        tests_run++; if ({m_awvalid, m_arvalid} !== 2'b10) begin tests_failed++; $display("FAIL write_over_read: got %b expected 10", {m_awvalid, m_arvalid}); end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        set_write(0, 32'h1000_0010, 32'hDEAD_BEEF);
        #1;
        tests_run++; if (m_awvalid !== 1'b0) begin tests_failed++; $display("FAIL sw_idle_awvalid: got %b expected 0", m_awvalid); end
        @(posedge clk); @(negedge clk); #1;
        tests_run++; if ({m_awvalid, m_wvalid, busy} !== 3'b111) begin tests_failed++; $display("FAIL sw_valids: got %b expected 111", {m_awvalid, m_wvalid, busy}); end
        tests_run++; if (m_awaddr !== 32'h1000_0010) begin tests_failed++; $display("FAIL sw_awaddr: got %h expected 10000010", m_awaddr); end
        tests_run++; if (m_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL sw_wdata: got %h expected deadbeef", m_wdata); end
        tests_run++; if (m_wstrb !== 4'hF) begin tests_failed++; $display("FAIL sw_wstrb: got %h expected f", m_wstrb); end
        m_awready = 1'b1; m_wready = 1'b1;
        #1;
        tests_run++; if ({s_awready, s_wready} !== 8'b0001_0001) begin tests_failed++; $display("FAIL sw_readies: got %b expected 00010001", {s_awready, s_wready}); end
        @(posedge clk); @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0;
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b00;
        #1;
        tests_run++; if (s_bvalid !== 4'b0001) begin tests_failed++; $display("FAIL sw_bvalid: got %b expected 0001", s_bvalid); end
        tests_run++; if ({m_bready, m_awvalid, s_bresp} !== 4'b1000) begin tests_failed++; $display("FAIL sw_wait_b: got %b expected 1000", {m_bready, m_awvalid, s_bresp}); end
        @(posedge clk); @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sw_back_idle: got %b expected 0", busy); end
        // last is now 0, so with 0 and 1 both asking, 1 must go first
        set_read(0, 32'h0000_0000);
        set_read(1, 32'h0000_0100);
        run_txn(1'b0, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
        tests_run++; if (r_tmo || r_id != 1) begin tests_failed++; $display("FAIL sw_last_updated: got %0d (timeout %b) expected 1", r_id, r_tmo); end
        run_txn(1'b0, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
        tests_run++; if (r_tmo || r_id != 0) begin tests_failed++; $display("FAIL sw_then_req0: got %0d (timeout %b) expected 0", r_id, r_tmo); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < N; i++) set_read(i, 32'(i) << 8);
        for (int t = 0; t < 2*N; t++) exp_q.push_back('{id: t % N, wr: 1'b0, addr: 32'(t % N) << 8, data: 32'hA0 + 32'(t % N)});
        for (int t = 0; t < 2*N; t++) begin
            run_txn(1'b1, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
            e = exp_q.pop_front();
            tests_run++; if (r_tmo || r_id != e.id || r_wr) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %0d (wr %b timeout %b) expected %0d", t, r_id, r_wr, r_tmo, e.id); end
            tests_run++; if (r_addr !== e.addr) begin tests_failed++; $display("FAIL rr_araddr[%0d]: got %h expected %h", t, r_addr, e.addr); end
            tests_run++; if (r_vec !== 4'(1 << e.id) || r_rdata !== e.data) begin tests_failed++; $display("FAIL rr_rvalid_rdata[%0d]: got %b/%h expected %b/%h", t, r_vec, r_rdata, 4'(1 << e.id), e.data); end
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rr_turnaround[%0d]: got busy %b expected 0", t, busy); end
        end
        s_arvalid = '0;
    endtask

    task automatic test_write_then_read();
        do_reset();
        set_write(1, 32'h0000_1100, 32'h1234_5678);
        set_read(1, 32'h0000_0100);
        set_read(2, 32'h0000_0200);
        exp_q.push_back('{id: 1, wr: 1'b1, addr: 32'h0000_1100, data: 32'h1234_5678});
        exp_q.push_back('{id: 2, wr: 1'b0, addr: 32'h0000_0200, data: 32'h0000_00A2});
        exp_q.push_back('{id: 1, wr: 1'b0, addr: 32'h0000_0100, data: 32'h0000_00A1});
        for (int t = 0; t < 3; t++) begin
            run_txn(1'b0, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
            e = exp_q.pop_front();
            tests_run++; if (r_tmo || r_id != e.id || r_wr != e.wr) begin tests_failed++; $display("FAIL wr_rd_order[%0d]: got id %0d wr %b (timeout %b) expected id %0d wr %b", t, r_id, r_wr, r_tmo, e.id, e.wr); end
            tests_run++; if (r_addr !== e.addr || (e.wr ? r_wdata : r_rdata) !== e.data) begin tests_failed++; $display("FAIL wr_rd_payload[%0d]: got %h/%h expected %h/%h", t, r_addr, (e.wr ? r_wdata : r_rdata), e.addr, e.data); end
            tests_run++; if (r_vec !== 4'(1 << e.id)) begin tests_failed++; $display("FAIL wr_rd_resp_route[%0d]: got %b expected %b", t, r_vec, 4'(1 << e.id)); end
        end
    endtask

    task automatic test_aw_before_w();
        do_reset();
        set_write(2, 32'h2000_0040, 32'h0BAD_F00D);
        s_wstrb[2*4 +: 4]  = 4'h3;
        s_awprot[2*3 +: 3] = 3'b101;
        @(posedge clk); @(negedge clk);
        m_awready = 1'b1;
        #1;
        tests_run++; if ({s_awready, s_wready} !== 8'b0100_0000) begin tests_failed++; $display("FAIL aww_readies: got %b expected 01000000", {s_awready, s_wready}); end
        tests_run++; if (m_awprot !== 3'b101 || m_wstrb !== 4'h3) begin tests_failed++; $display("FAIL aww_prot_strb: got %b/%h expected 101/3", m_awprot, m_wstrb); end
        @(posedge clk); @(negedge clk);
        m_awready = 1'b0;
        s_awvalid[2] = 1'b0;
        #1;
        tests_run++; if ({m_awvalid, m_wvalid} !== 2'b01) begin tests_failed++; $display("FAIL aww_aw_dropped: got %b expected 01", {m_awvalid, m_wvalid}); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk); #1;
            tests_run++; if ({m_wvalid, m_bready} !== 2'b10) begin tests_failed++; $display("FAIL aww_hold[%0d]: got %b expected 10", k, {m_wvalid, m_bready}); end
        end
        m_wready = 1'b1;
        #1;
        tests_run++; if (s_wready !== 4'b0100) begin tests_failed++; $display("FAIL aww_wready: got %b expected 0100", s_wready); end
        @(posedge clk); @(negedge clk);
        m_wready = 1'b0;
        s_wvalid[2] = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        tests_run++; if ({m_bready, m_wvalid} !== 2'b10) begin tests_failed++; $display("FAIL aww_wait_b: got %b expected 10", {m_bready, m_wvalid}); end
        tests_run++; if (s_bvalid !== 4'b0100 || s_bresp !== 2'b10) begin tests_failed++; $display("FAIL aww_bresp: got %b/%b expected 0100/10", s_bvalid, s_bresp); end
        @(posedge clk); @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || s_bvalid !== 4'b0) begin tests_failed++; $display("FAIL aww_single_b: got busy %b bvalid %b expected 0/0000", busy, s_bvalid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_read(1, 32'h0000_0100);
        s_rready = 4'b1101;
        @(posedge clk); @(negedge clk); #1;
        tests_run++; if (m_arvalid !== 1'b1 || grant_id !== 3'd1) begin tests_failed++; $display("FAIL bp_grant: got %b/%0d expected 1/1", m_arvalid, grant_id); end
        m_arready = 1'b1;
        @(posedge clk); @(negedge clk);
        m_arready = 1'b0;
        s_arvalid[1] = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++; if ({m_rready, busy} !== 2'b01 || s_rvalid !== 4'b0010 || s_rdata !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL bp_hold[%0d]: got rready %b busy %b rvalid %b rdata %h expected 0 1 0010 cafe0001", k, m_rready, busy, s_rvalid, s_rdata); end
            @(posedge clk); @(negedge clk);
        end
        s_rready[1] = 1'b1;
        #1;
        tests_run++; if (m_rready !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got %b expected 1", m_rready); end
        @(posedge clk); @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_complete: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_write(3, 32'h0000_3000, 32'h3333_3333);
        s_bready = 4'b0000;
        @(posedge clk); @(negedge clk);
        m_awready = 1'b1; m_wready = 1'b1;
        @(posedge clk); @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0;
        s_awvalid[3] = 1'b0; s_wvalid[3] = 1'b0;
        m_bvalid = 1'b1;
        #1;
        tests_run++; if (s_bvalid !== 4'b1000 || m_bready !== 1'b0) begin tests_failed++; $display("FAIL rm_wait_b: got %b/%b expected 1000/0", s_bvalid, m_bready); end
        s_bready = '1;
        res = 1'b1;
        #1;
        tests_run++; if (s_bvalid !== 4'b0 || m_bready !== 1'b0 || busy !== 1'b0 || grant_id !== 3'd0) begin tests_failed++; $display("FAIL rm_abort: got bvalid %b bready %b busy %b grant %0d expected 0000 0 0 0", s_bvalid, m_bready, busy, grant_id); end
        @(negedge clk);
        res = 1'b0;
        m_bvalid = 1'b0;
        set_read(2, 32'h0000_0200);
        set_read(0, 32'h0000_0000);
        #1;
        run_txn(1'b0, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
        tests_run++; if (r_tmo || r_id != 0) begin tests_failed++; $display("FAIL rm_first_after_reset: got %0d (timeout %b) expected 0", r_id, r_tmo); end
        run_txn(1'b0, r_id, r_wr, r_addr, r_wdata, r_vec, r_rdata, r_tmo);
        tests_run++; if (r_tmo || r_id != 2) begin tests_failed++; $display("FAIL rm_second_after_reset: got %0d (timeout %b) expected 2", r_id, r_tmo); end
    endtask

    initial begin
        res = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_write_then_read();
        test_aw_before_w();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
